// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//
// Coefficient-programming master for the reconfigurable transposed FIR filter.
// Host taps arrive over a valid/ready handshake. Each tap becomes one write
// strobe on the coefficient-update bus. Slots above the requested count are
// written with zero, so every coefficient slot is rewritten on each update.
//
// Ports
//   iClk_12M           system clock (12 MHz)
//   iRsn               asynchronous, active-high reset
//   iStart             one-cycle update request, sampled only when idle
//   iNumOfCoeff[5:0]   number of host-supplied taps (legal 1..NUM_TAPS)
//   iCoeffValid        host tap valid
//   iCoeffData[15:0]   host tap value (signed, passed through untouched)
//   oCoeffReady        loader accepts a tap this cycle
//   oCoeffiUpdateFlag  update in progress (to filter iCoeffiUpdateFlag)
//   oCsnRam, oWrnRam   active-low chip select / write enable
//   oAddrRam[3:0]      slot address within the bank, 1..BANK_DEPTH
//   oBank[1:0]         bank index of the current write (monitoring)
//   oWrDtRam[15:0]     write data
//   oNumOfCoeff[5:0]   tap count of the last completed update
//   oBusy              high whenever not idle
//   oDone              one-cycle pulse when an update completes
//   oErr               one-cycle pulse on a start with an illegal count
//
// All outputs are registered: each output register is loaded from the state
// being entered, so it is valid in the same cycle as that state.
// -----------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int NUM_TAPS   = 33,
    parameter int BANK_DEPTH = 10
) (
    input  logic        iClk_12M,
    input  logic        iRsn,
    input  logic        iStart,
    input  logic [5:0]  iNumOfCoeff,
    input  logic        iCoeffValid,
    input  logic [15:0] iCoeffData,
    output logic        oCoeffReady,
    output logic        oCoeffiUpdateFlag,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic [3:0]  oAddrRam,
    output logic [1:0]  oBank,
    output logic [15:0] oWrDtRam,
    output logic [5:0]  oNumOfCoeff,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_DATA = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] GAP       = 3'd3;
    localparam logic [2:0] FILL      = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [5:0] NUM_TAPS_W   = 6'(NUM_TAPS);
    localparam logic [3:0] BANK_DEPTH_W = 4'(BANK_DEPTH);

    logic [2:0] state;
    logic [2:0] stateNext;

    logic [5:0] numLatched;   // N of the update in progress
    logic [5:0] slotIdx;      // k, 1-based slot index
    // Bank/address of slot k, tracked incrementally instead of dividing k.
    logic [1:0] slotBank;
    logic [3:0] slotAddr;

    logic [5:0] slotIdxInc;
    logic [1:0] slotBankInc;
    logic [3:0] slotAddrInc;

    logic startLegal;
    logic startIllegal;
    logic strobeNext;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        slotIdxInc  = slotIdx + 6'd1;
        slotBankInc = slotBank;
        slotAddrInc = slotAddr + 4'd1;
        if (slotAddr == BANK_DEPTH_W) begin
            slotAddrInc = 4'd1;
            slotBankInc = slotBank + 2'd1;
        end
    end

    assign startLegal   = iStart && (iNumOfCoeff != 6'd0) && (iNumOfCoeff <= NUM_TAPS_W);
    assign startIllegal = iStart && !startLegal;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (startLegal) stateNext = WAIT_DATA;
            // oCoeffReady is high exactly in WAIT_DATA, so valid alone
            // completes the handshake here.
            WAIT_DATA: if (iCoeffValid) stateNext = WRITE;
            WRITE:     stateNext = GAP;
            GAP: begin
                if (slotIdxInc <= numLatched)      stateNext = WAIT_DATA;
                else if (slotIdxInc <= NUM_TAPS_W) stateNext = FILL;
                else                               stateNext = DONE;
            end
            FILL:      stateNext = GAP;
            DONE:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    assign strobeNext = (stateNext == WRITE) || (stateNext == FILL);

    always_ff @(posedge iClk_12M or posedge iRsn) begin
        if (iRsn) begin
            state             <= IDLE;
            numLatched        <= 6'd0;
            slotIdx           <= 6'd0;
            slotBank          <= 2'd0;
            slotAddr          <= 4'd0;
            oCoeffReady       <= 1'b0;
            oCoeffiUpdateFlag <= 1'b0;
            oCsnRam           <= 1'b1;
            oWrnRam           <= 1'b1;
            oAddrRam          <= 4'd0;
            oBank             <= 2'd0;
            oWrDtRam          <= 16'd0;
            oNumOfCoeff       <= 6'd0;
            oBusy             <= 1'b0;
            oDone             <= 1'b0;
            oErr              <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees the pre-edge value of the others regardless of order.
            state             <= stateNext;
            oCoeffReady       <= (stateNext == WAIT_DATA);
            oCoeffiUpdateFlag <= (stateNext != IDLE) && (stateNext != DONE);
            oBusy             <= (stateNext != IDLE);
            oDone             <= (stateNext == DONE);
            oErr              <= (state == IDLE) && startIllegal;
            oCsnRam           <= !strobeNext;
            oWrnRam           <= !strobeNext;

            case (state)
                IDLE: begin
                    if (startLegal) begin
                        numLatched <= iNumOfCoeff;
                        slotIdx    <= 6'd1;
                        slotBank   <= 2'd0;
                        slotAddr   <= 4'd1;
                    end
                end
                WAIT_DATA: begin
                    // The data register itself holds the accepted tap.
                    if (iCoeffValid) begin
                        oBank    <= slotBank;
                        oAddrRam <= slotAddr;
                        oWrDtRam <= iCoeffData;
                    end
                end
                GAP: begin
                    slotIdx  <= slotIdxInc;
                    slotBank <= slotBankInc;
                    slotAddr <= slotAddrInc;
                    if (stateNext == FILL) begin
                        oBank    <= slotBankInc;
                        oAddrRam <= slotAddrInc;
                        oWrDtRam <= 16'd0;
                    end
                    // Published on entry to DONE so it is valid with oDone.
                    if (stateNext == DONE) begin
                        oNumOfCoeff <= numLatched;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
//
// Directed bench for fir_coeff_loader. A scoreboard holds the 33 writes an
// update must produce (bank/address from slot arithmetic, data from the host
// taps or zero); a compare process checks every strobe and the bus rules on
// each cycle. Directed tests pin cycle numbers and selected writes literally.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

    localparam int NTAPS = 33;
    localparam int DEPTH = 10;

    logic        iClk_12M = 1'b0;
    logic        iRsn = 1'b1;
    logic        iStart = 1'b0;
    logic [5:0]  iNumOfCoeff = 6'd0;
    logic        iCoeffValid = 1'b0;
    logic [15:0] iCoeffData = 16'd0;
    logic        oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam;
    logic [3:0]  oAddrRam;
    logic [1:0]  oBank;
    logic [15:0] oWrDtRam;
    logic [5:0]  oNumOfCoeff;
    logic        oBusy, oDone, oErr;

    fir_coeff_loader dut (
        .iClk_12M(iClk_12M), .iRsn(iRsn), .iStart(iStart),
        .iNumOfCoeff(iNumOfCoeff), .iCoeffValid(iCoeffValid),
        .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady),
        .oCoeffiUpdateFlag(oCoeffiUpdateFlag), .oCsnRam(oCsnRam),
        .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oBank(oBank),
        .oWrDtRam(oWrDtRam), .oNumOfCoeff(oNumOfCoeff), .oBusy(oBusy),
        .oDone(oDone), .oErr(oErr)
    );

    always #5 iClk_12M = ~iClk_12M;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    typedef struct packed {
        logic [1:0]  bank;
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         expQ[$];
    logic [5:0]  expN = 6'd0;
    logic [15:0] tapVals [0:NTAPS-1];

    int cyc = 0;
    int startCyc = 0;
    always @(posedge iClk_12M) cyc <= cyc + 1;

    // Observed strobes of the current load.
    int         obsCnt = 0;
    int         obsCyc  [0:63];
    logic [1:0] obsBank [0:63];
    logic [3:0] obsAddr [0:63];
    logic [15:0] obsData [0:63];
    int         doneCnt = 0;
    int         doneCyc = -1;

    // Scoreboard: the write sequence an update of n host taps must produce.
    task automatic expect_load(input int n);
        wr_t w;
        expQ.delete();
        for (int k = 1; k <= NTAPS; k++) begin
            w.bank = 2'((k - 1) / DEPTH);
            w.addr = 4'(((k - 1) % DEPTH) + 1);
            w.data = (k <= n) ? tapVals[k-1] : 16'h0000;
            expQ.push_back(w);
        end
        expN = 6'(n);
    endtask

    // Compare process.
    logic prevHs = 1'b0;
    logic prevCsn = 1'b1;
    wr_t  cur;
    always @(negedge iClk_12M) begin
        if (iRsn) begin
            prevHs  = 1'b0;
            prevCsn = 1'b1;
        end else begin
            if (!oCsnRam) begin
                check("strobe_gap_before", 32'(prevCsn), 32'd1);
                check("wrn_with_csn", 32'(oWrnRam), 32'd0);
                if (expQ.size() == 0) begin
                    check("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = expQ.pop_front();
                    check("wr_bank", 32'(oBank), 32'(cur.bank));
                    check("wr_addr", 32'(oAddrRam), 32'(cur.addr));
                    check("wr_data", 32'(oWrDtRam), 32'(cur.data));
                end
                if (obsCnt < 64) begin
                    obsCyc[obsCnt]  = cyc - startCyc;
                    obsBank[obsCnt] = oBank;
                    obsAddr[obsCnt] = oAddrRam;
                    obsData[obsCnt] = oWrDtRam;
                end
                obsCnt++;
            end else begin
                check("wrn_idle", 32'(oWrnRam), 32'd1);
            end
            if (prevHs) check("hs_to_strobe", 32'(oCsnRam), 32'd0);
            check("flag_vs_busy", 32'(oCoeffiUpdateFlag), 32'(oBusy && !oDone));
            if (oDone) begin
                check("done_num", 32'(oNumOfCoeff), 32'(expN));
                check("done_all_written", 32'(expQ.size()), 32'd0);
                doneCnt++;
                doneCyc = cyc - startCyc;
            end
            prevHs  = oCoeffReady && iCoeffValid;
            prevCsn = oCsnRam;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_csn"},   32'(oCsnRam), 32'd1);
        check({tag, "_wrn"},   32'(oWrnRam), 32'd1);
        check({tag, "_addr"},  32'(oAddrRam), 32'd0);
        check({tag, "_bank"},  32'(oBank), 32'd0);
        check({tag, "_data"},  32'(oWrDtRam), 32'd0);
        check({tag, "_flag"},  32'(oCoeffiUpdateFlag), 32'd0);
        check({tag, "_ready"}, 32'(oCoeffReady), 32'd0);
        check({tag, "_busy"},  32'(oBusy), 32'd0);
        check({tag, "_done"},  32'(oDone), 32'd0);
        check({tag, "_err"},   32'(oErr), 32'd0);
        check({tag, "_num"},   32'(oNumOfCoeff), 32'd0);
    endtask

    int errDuringLoad;

    // Runs one update with valid held high except for an optional stall.
    // busyStartAt: cycle at which a second iStart is injected (-1: none).
    // abortAfter: assert reset once this many strobes were seen (0: none).
    task automatic run_load(input int n, input int stallAt, input int stallLen,
                            input int busyStartAt, input int abortAfter);
        int  idx = 0;
        int  stallLeft = 0;
        int  budget = 0;
        int  rel;
        int  doneBefore;
        bit  hs;
        bit  seenDone = 0;
        bit  aborted = 0;
        expect_load(n);
        obsCnt = 0;
        doneCyc = -1;
        errDuringLoad = 0;
        doneBefore = doneCnt;
        @(posedge iClk_12M); #1;
        iNumOfCoeff = 6'(n);
        iStart      = 1'b1;
        iCoeffValid = 1'b0;
        startCyc    = cyc;
        @(posedge iClk_12M); #1;
        iStart = 1'b0;
        while (!seenDone && !aborted && budget < 400) begin
            iCoeffValid = (idx < n) && (stallLeft == 0);
            iCoeffData  = (idx < n) ? tapVals[idx] : 16'hDEAD;
            @(negedge iClk_12M); #1;
            rel = cyc - startCyc;
            hs = iCoeffValid && oCoeffReady;
            seenDone = oDone;
            errDuringLoad += int'(oErr);
            if (stallLeft > 0 && rel >= 4) begin
                check("stall_ready", 32'(oCoeffReady), 32'd1);
                check("stall_flag", 32'(oCoeffiUpdateFlag), 32'd1);
                check("stall_no_strobe", 32'(oCsnRam), 32'd1);
            end
            if (abortAfter > 0 && obsCnt >= abortAfter) begin
                iRsn = 1'b1;
                #1;
                check_reset_values("midrst");
                aborted = 1;
            end else begin
                @(posedge iClk_12M); #1;
                rel = cyc - startCyc;
                if (stallLeft > 0) stallLeft--;
                if (hs) begin
                    idx++;
                    if (idx == stallAt) stallLeft = stallLen;
                end
                iStart      = (rel == busyStartAt);
                iNumOfCoeff = (rel == busyStartAt) ? 6'd5 : 6'(n);
            end
            budget++;
        end
        iStart = 1'b0;
        iCoeffValid = 1'b0;
        check("load_timeout", 32'(seenDone || aborted), 32'd1);
        if (!aborted) check("done_pulses", 32'(doneCnt - doneBefore), 32'd1);
    endtask

    task automatic illegal_start(input logic [5:0] cnt, input logic [5:0] numBefore);
        int errs = 0;
        int busys = 0;
        @(posedge iClk_12M); #1;
        iNumOfCoeff = cnt;
        iStart = 1'b1;
        @(posedge iClk_12M); #1;
        iStart = 1'b0;
        @(negedge iClk_12M);
        check("err_at_cycle1", 32'(oErr), 32'd1);
        errs += int'(oErr);
        busys += int'(oBusy);
        repeat (4) begin
            @(negedge iClk_12M);
            errs += int'(oErr);
            busys += int'(oBusy);
        end
        check("err_pulse_count", 32'(errs), 32'd1);
        check("err_busy", 32'(busys), 32'd0);
        check("err_num_kept", 32'(oNumOfCoeff), 32'(numBefore));
        check("err_csn", 32'(oCsnRam), 32'd1);
    endtask

    initial begin
        int zeros;
        int doneSaved;

        // Reset with random inputs.
        repeat (8) begin
            @(posedge iClk_12M); #1;
            iStart      = 1'($urandom_range(0, 1));
            iNumOfCoeff = 6'($urandom_range(0, 63));
            iCoeffValid = 1'($urandom_range(0, 1));
            iCoeffData  = 16'($urandom_range(0, 65535));
            @(negedge iClk_12M);
            check_reset_values("rst");
        end
        @(posedge iClk_12M); #1;
        iRsn = 1'b0;
        iStart = 1'b0;
        iCoeffValid = 1'b0;
        iNumOfCoeff = 6'd0;
        @(negedge iClk_12M);
        check_reset_values("post_rst");

        // Full load, N=33, taps 1..33.
        for (int i = 0; i < NTAPS; i++) tapVals[i] = 16'(i + 1);
        run_load(33, -1, 0, -1, 0);
        check("full_strobes", 32'(obsCnt), 32'd33);
        check("full_first_cyc", 32'(obsCyc[0]), 32'd2);
        check("full_last_cyc", 32'(obsCyc[32]), 32'd98);
        check("full_done_cyc", 32'(doneCyc), 32'd100);
        check("full_k10", {26'd0, obsBank[9], obsAddr[9]}, {26'd0, 2'd0, 4'd10});
        check("full_k11", {26'd0, obsBank[10], obsAddr[10]}, {26'd0, 2'd1, 4'd1});
        check("full_k33", {26'd0, obsBank[32], obsAddr[32]}, {26'd0, 2'd3, 4'd3});
        check("full_k33_data", 32'(obsData[32]), 32'h0021);
        check("full_num", 32'(oNumOfCoeff), 32'd33);

        // Partial load with zero-fill, N=12, alternating extremes.
        for (int i = 0; i < NTAPS; i++) tapVals[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
        run_load(12, -1, 0, -1, 0);
        zeros = 0;
        for (int i = 12; i < 33; i++) if (obsData[i] == 16'h0000) zeros++;
        check("part_strobes", 32'(obsCnt), 32'd33);
        check("part_fill_zeros", 32'(zeros), 32'd21);
        check("part_k12_data", 32'(obsData[11]), 32'h8000);
        check("part_k1_data", 32'(obsData[0]), 32'h7FFF);
        check("part_fill1", {10'd0, obsBank[12], obsAddr[12], obsData[12]},
                            {10'd0, 2'd1, 4'd3, 16'h0000});
        check("part_fill1_cyc", 32'(obsCyc[12]), 32'd37);
        check("part_done_cyc", 32'(doneCyc), 32'd79);
        check("part_num", 32'(oNumOfCoeff), 32'd12);

        // Host stall before tap 2, with a start request injected mid-load.
        tapVals[0] = 16'h1111; tapVals[1] = 16'h2222; tapVals[2] = 16'h3333;
        run_load(3, 1, 20, 10, 0);
        check("stall_first_cyc", 32'(obsCyc[0]), 32'd2);
        check("stall_resume_cyc", 32'(obsCyc[1]), 32'd23);
        check("stall_third_cyc", 32'(obsCyc[2]), 32'd26);
        check("stall_done_cyc", 32'(doneCyc), 32'd88);
        check("busy_start_num", 32'(oNumOfCoeff), 32'd3);
        check("busy_start_err", 32'(errDuringLoad), 32'd0);
        check("stall_strobes", 32'(obsCnt), 32'd33);

        // Illegal starts.
        illegal_start(6'd0, 6'd3);
        illegal_start(6'd34, 6'd3);

        // Reset after the 5th strobe, then a fresh N=2 load.
        for (int i = 0; i < NTAPS; i++) tapVals[i] = 16'(16'h0100 + i);
        doneSaved = doneCnt;
        run_load(33, -1, 0, -1, 5);
        @(posedge iClk_12M); #1;
        iRsn = 1'b0;
        repeat (3) @(negedge iClk_12M);
        check("midrst_no_done", 32'(doneCnt), 32'(doneSaved));
        check("midrst_num", 32'(oNumOfCoeff), 32'd0);
        check("midrst_busy", 32'(oBusy), 32'd0);
        tapVals[0] = 16'h1234; tapVals[1] = 16'hABCD;
        run_load(2, -1, 0, -1, 0);
        check("after_rst_strobes", 32'(obsCnt), 32'd33);
        check("after_rst_k2", 32'(obsData[1]), 32'hABCD);
        check("after_rst_k3", 32'(obsData[2]), 32'h0000);
        check("after_rst_done_cyc", 32'(doneCyc), 32'd69);
        check("after_rst_num", 32'(oNumOfCoeff), 32'd2);

        repeat (2) @(posedge iClk_12M);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-programming master for the reconfigurable transposed FIR filter. Accepts a stream of signed 16-bit taps from a host over a valid/ready handshake and drives the filter's coefficient-update bus with one write transaction per tap. The bus signals are chip-select, write-enable, 4-bit address, 16-bit data and the update flag. Taps above the requested count are zero-filled, so all 33 coefficient slots are always rewritten.

## Interface
- NUM_TAPS, 33: total coefficient slots in the filter.
- BANK_DEPTH, 10: slots per coefficient RAM bank. Addresses run 1..BANK_DEPTH within a bank.
- iClk_12M  input  1  system clock, 12 MHz.
- iRsn  input  1  reset. Asynchronous, active-high.
- iStart  input  1  one-cycle request to start an update. Sampled only in IDLE.
- iNumOfCoeff  input  6  number of host-supplied taps. Valid range 1..33.
- iCoeffValid  input  1  host tap valid.
- iCoeffData  input  16  host tap value, signed.
- oCoeffReady  output  1  loader can accept a tap this cycle.
- oCoeffiUpdateFlag  output  1  update in progress. Drives the filter's iCoeffiUpdateFlag.
- oCsnRam  output  1  RAM chip select, active-low.
- oWrnRam  output  1  RAM write enable, active-low.
- oAddrRam  output  4  slot address within the bank, 1..10.
- oBank  output  2  bank index 0..3 of the current write. For monitoring.
- oWrDtRam  output  16  write data, signed.
- oNumOfCoeff  output  6  tap count of the last completed update. Drives the filter's iNumOfCoeff.
- oBusy  output  1  high in every state except IDLE.
- oDone  output  1  one-cycle pulse when an update completes.
- oErr  output  1  one-cycle pulse when iStart arrives with iNumOfCoeff of 0 or greater than 33.

## Operation
- States: IDLE, WAIT_DATA, WRITE, GAP, FILL, DONE.
- IDLE
  - iStart with iNumOfCoeff in 1..33: latch N, clear the slot index k to 1, go to WAIT_DATA.
  - iStart with an illegal count: pulse oErr next cycle, stay in IDLE, leave all other outputs unchanged.
- WAIT_DATA
  - oCoeffReady=1.
  - On iCoeffValid and oCoeffReady: latch iCoeffData, go to WRITE.
  - Host may stall indefinitely; there is no timeout.
- WRITE (one cycle)
  - oCsnRam=0, oWrnRam=0.
  - oBank=(k-1)/BANK_DEPTH, oAddrRam=((k-1) mod BANK_DEPTH)+1, oWrDtRam=latched tap.
  - Go to GAP.
- GAP (one cycle)
  - oCsnRam=1, oWrnRam=1. Address and data hold their last values.
  - k increments.
  - Next state: WAIT_DATA if k<=N; FILL if N<k<=33; otherwise DONE.
- FILL (one cycle)
  - Same bus activity as WRITE, with oWrDtRam=0.
  - oCoeffReady stays 0.
  - Go to GAP.
- DONE (one cycle)
  - oDone=1, oNumOfCoeff<=N, oCoeffiUpdateFlag<=0.
  - Go to IDLE.
- oCoeffiUpdateFlag is 1 in every state from WAIT_DATA through GAP.
- iStart outside IDLE is ignored. iCoeffValid outside WAIT_DATA is ignored; the host must hold the tap.
- Bank wrap: k=10 gives bank 0 addr 10; k=11 gives bank 1 addr 1; k=31..33 give bank 3 addr 1..3.
- Address and data pass through unmodified; there is no arithmetic on the tap value.
- Reset mid-update: return to IDLE immediately. oNumOfCoeff reverts to 0. No partial DONE pulse.

## Timing
- Reset values:
  - oCsnRam=1, oWrnRam=1.
  - oAddrRam=0, oBank=0, oWrDtRam=0.
  - oCoeffiUpdateFlag=0, oCoeffReady=0, oBusy=0, oDone=0, oErr=0.
  - oNumOfCoeff=0.
- All outputs are registered.
- iStart at cycle 0: WAIT_DATA from cycle 1, with oCoeffReady and oCoeffiUpdateFlag high at cycle 1.
- Handshake at cycle t: write strobe (oCsnRam=0) at t+1, GAP at t+2, oCoeffReady high again at t+3.
- Maximum host tap rate is one per 3 cycles. Zero-fill writes cost 2 cycles each.
- With iCoeffValid held high, total duration is 1 + 3N + 2(33-N) cycles, then one DONE cycle. For N=33 the last GAP is at cycle 99 and oDone is at cycle 100.
- Write strobes are always exactly one cycle wide and separated by at least one idle cycle.

## Test plan
- Reset: assert iRsn with random inputs. All outputs must equal their reset values; oCsnRam=1 throughout.
- Full load: N=33, taps 0x0001..0x0021, valid held high.
  - Expect 33 strobes at cycles 2,5,...,98.
  - Bank/address sequence: 0/1..0/10, 1/1..1/10, 2/1..2/10, 3/1..3/3.
  - oDone at cycle 100 with oNumOfCoeff=33.
- Partial load with zero-fill: N=12, taps 0x7FFF and 0x8000 alternating.
  - Expect 12 data strobes, then 21 strobes with data 0.
  - First fill write at bank 1 addr 3.
  - Final oNumOfCoeff=12.
- Host stall: N=3, valid dropped for 20 cycles before tap 2.
  - oCoeffReady stays high, no strobe occurs, flag stays 1.
  - Write resumes exactly 1 cycle after the handshake.
- Illegal and busy start:
  - iStart with iNumOfCoeff=0: oErr pulses once, oBusy stays 0.
  - iStart with 34: oErr pulses once.
  - iStart during a load: no effect on the load.
- Reset mid-update: assert iRsn after the 5th strobe.
  - Outputs must equal reset values immediately.
  - A new N=2 load afterwards completes normally with oNumOfCoeff=2.
